// File: rtl/uart_pixel_wr_ctrl_pkg.sv
// Shared constants for the UART->RAM->TFT path: default frame geometry,
// pixel format width and the byte-phase encoding of the pixel packer.
package uart_pixel_wr_ctrl_pkg;

  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;
  localparam int RGB565_W  = 16;
  localparam int BYTE_W    = RGB565_W / 2;

  // Byte phase of the packer: waiting for the high byte or the low byte.
  localparam logic [0:0] PH_HI = 1'b0;
  localparam logic [0:0] PH_LO = 1'b1;

endpackage

// File: rtl/uart_pixel_wr_ctrl.sv
// Packs UART bytes (high byte first) into RGB565 pixels and writes them to the
// frame RAM at a wrapping address; an idle timer drops a stranded high byte.
module uart_pixel_wr_ctrl
  import uart_pixel_wr_ctrl_pkg::*;
#(
  parameter int IMG_W       = IMG_W_DEF,
  parameter int IMG_H       = IMG_H_DEF,
  parameter int ADDR_W      = 15,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                Clk,
  input  logic                Reset_n,
  input  logic [BYTE_W-1:0]   rx_data,
  input  logic                rx_done,
  input  logic                clr,
  output logic                ram_wren,
  output logic [ADDR_W-1:0]   ram_waddr,
  output logic [RGB565_W-1:0] ram_wdata,
  output logic                frame_done,
  output logic                timeout
);

  localparam int                CNT_W     = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0]  IDLE_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [0:0]        phase;
  logic [BYTE_W-1:0] hi_reg;
  logic [CNT_W-1:0]  idle_cnt;
  logic [ADDR_W-1:0] pix_addr;

  // NOTE: all state, including the registered RAM address/data, uses
  // non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      phase      <= PH_HI;
      hi_reg     <= '0;
      idle_cnt   <= '0;
      pix_addr   <= '0;
      ram_wren   <= 1'b0;
      ram_waddr  <= '0;
      ram_wdata  <= '0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      ram_wren   <= 1'b0;
      frame_done <= 1'b0;
      timeout    <= 1'b0;

      // clr outranks a byte arriving in the same cycle; that byte is lost.
      if (clr) begin
        phase    <= PH_HI;
        hi_reg   <= '0;
        idle_cnt <= '0;
        pix_addr <= '0;
      end else if (rx_done) begin
        idle_cnt <= '0;
        if (phase == PH_HI) begin
          hi_reg <= rx_data;
          phase  <= PH_LO;
        end else begin
          ram_wren   <= 1'b1;
          ram_waddr  <= pix_addr;
          ram_wdata  <= {hi_reg, rx_data};
          frame_done <= (pix_addr == LAST_ADDR);
          pix_addr   <= (pix_addr == LAST_ADDR) ? '0 : pix_addr + 1'b1;
          phase      <= PH_HI;
        end
      end else if (phase == PH_LO) begin
        if (idle_cnt == IDLE_LAST) begin
          timeout  <= 1'b1;
          phase    <= PH_HI;
          hi_reg   <= '0;
          idle_cnt <= '0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_pixel_wr_ctrl.sv
// Self-checking bench for uart_pixel_wr_ctrl: directed scenarios with literal
// expectations plus randomized byte traffic against an event-level model.
module tb_uart_pixel_wr_ctrl;

  localparam int IMG_W = 4;
  localparam int IMG_H = 2;
  localparam int ADDR_W = 3;
  localparam int TIMEOUT_CYC = 100;
  localparam int FRAME = IMG_W * IMG_H;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic [7:0]        rx_data = '0;
  logic              rx_done = 1'b0;
  logic              clr = 1'b0;
  logic              ram_wren;
  logic [ADDR_W-1:0] ram_waddr;
  logic [15:0]       ram_wdata;
  logic              frame_done;
  logic              timeout;

  uart_pixel_wr_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .rx_data(rx_data), .rx_done(rx_done), .clr(clr),
    .ram_wren(ram_wren), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .frame_done(frame_done), .timeout(timeout)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Event-level model: a pending high byte expires TIMEOUT_CYC edges after capture.
  bit   m_have;
  int   m_hi, m_addr, m_since;
  logic e_wren, e_fd, e_to;
  int   e_addr, e_data;

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      m_have = 0; m_hi = 0; m_addr = 0; m_since = 0;
      e_wren = 0; e_fd = 0; e_to = 0; e_addr = 0; e_data = 0;
    end else begin
      cyc++;
      e_wren = 0; e_fd = 0; e_to = 0;
      if (clr) begin
        m_have = 0; m_addr = 0;
      end else if (rx_done) begin
        if (!m_have) begin
          m_have = 1; m_hi = int'(rx_data); m_since = 0;
        end else begin
          e_wren = 1; e_addr = m_addr; e_data = m_hi * 256 + int'(rx_data);
          e_fd = (m_addr == FRAME - 1);
          m_addr = (m_addr + 1) % FRAME;
          m_have = 0;
        end
      end else if (m_have) begin
        m_since++;
        if (m_since == TIMEOUT_CYC) begin
          e_to = 1; m_have = 0;
        end
      end
    end
  end

  // Compare process plus a monitor that logs what actually reached the RAM port.
  typedef struct { int addr; int data; } wr_t;
  wr_t wlog[$];
  int  n_to = 0, n_fd = 0, fd_addr = -1, to_cyc = -1;

  always @(negedge Clk) begin
    check("wren", int'(ram_wren), int'(e_wren));
    check("frame_done", int'(frame_done), int'(e_fd));
    check("timeout", int'(timeout), int'(e_to));
    check("waddr", int'(ram_waddr), e_addr);
    check("wdata", int'(ram_wdata), e_data);
    if (ram_wren) wlog.push_back('{int'(ram_waddr), int'(ram_wdata)});
    if (timeout) begin n_to++; to_cyc = cyc; end
    if (frame_done) begin n_fd++; fd_addr = int'(ram_waddr); end
  end

  // Called on a negedge; returns on the next negedge with the byte consumed.
  task automatic send_byte(input logic [7:0] b);
    rx_done = 1'b1; rx_data = b;
    @(negedge Clk);
    rx_done = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge Clk);
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge Clk);
  endtask

  int base, cap_cyc;

  initial begin
    idle(2);
    check("reset_wren", int'(ram_wren), 0);
    check("reset_addr", int'(ram_waddr), 0);
    check("reset_data", int'(ram_wdata), 0);
    check("reset_pulses", int'({frame_done, timeout}), 0);
    Reset_n = 1'b1;
    idle(2);

    // 1: spaced bytes, one-cycle write latency after the low byte
    wlog.delete();
    send_byte(8'h5a); idle(19);
    send_byte(8'h43);
    check("s1_latency", int'(ram_wren), 1);
    idle(19);
    send_byte(8'h78); idle(19); send_byte(8'h9a); idle(19);
    send_byte(8'hbc); idle(19); send_byte(8'hde); idle(5);
    check("s1_count", wlog.size(), 3);
    if (wlog.size() == 3) begin
      check("s1_w0", wlog[0].addr * 65536 + wlog[0].data, 32'h0_5a43);
      check("s1_w1", wlog[1].addr * 65536 + wlog[1].data, 32'h1_789a);
      check("s1_w2", wlog[2].addr * 65536 + wlog[2].data, 32'h2_bcde);
    end

    // 2: full frame back-to-back, wrap and frame_done on the last address
    pulse_clr(); idle(2);
    wlog.delete(); n_fd = 0;
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    idle(3);
    check("s2_count", wlog.size(), 8);
    for (int i = 0; i < 8 && i < wlog.size(); i++) begin
      check("s2_addr", wlog[i].addr, i);
      check("s2_data", wlog[i].data, (2 * i) * 256 + 2 * i + 1);
    end
    check("s2_fd_count", n_fd, 1);
    check("s2_fd_addr", fd_addr, 7);
    send_byte(8'hc1); send_byte(8'hc2); idle(2);
    check("s2_wrap", wlog[$].addr * 65536 + wlog[$].data, 32'h0_c1c2);

    // 3: stranded high byte times out exactly TIMEOUT_CYC edges after capture
    n_to = 0; wlog.delete();
    send_byte(8'h11); cap_cyc = cyc;
    idle(150);
    check("s3_to_count", n_to, 1);
    check("s3_to_cycle", to_cyc - cap_cyc, TIMEOUT_CYC);
    check("s3_no_write", wlog.size(), 0);
    send_byte(8'h22); send_byte(8'h33); idle(2);
    check("s3_write", wlog.size() == 1 ? wlog[0].addr * 65536 + wlog[0].data : -1, 32'h1_2233);

    // 4: clr together with a low byte drops it and restarts at address 0
    wlog.delete();
    send_byte(8'haa);
    clr = 1'b1; send_byte(8'hbb); clr = 1'b0;
    idle(2);
    check("s4_no_write", wlog.size(), 0);
    send_byte(8'h01); send_byte(8'h02); idle(2);
    check("s4_write", wlog.size() == 1 ? wlog[0].addr * 65536 + wlog[0].data : -1, 32'h0_0102);

    // 5: asynchronous reset clears an in-flight write and a pending high byte
    send_byte(8'h12); send_byte(8'h34);
    check("s5_inflight", int'(ram_wren), 1);
    #1 Reset_n = 1'b0;
    #1 check("s5_async_wren", int'(ram_wren), 0);
    check("s5_async_addr", int'(ram_waddr), 0);
    check("s5_async_data", int'(ram_wdata), 0);
    @(negedge Clk); idle(2); Reset_n = 1'b1; idle(2);
    send_byte(8'h44); idle(5);
    Reset_n = 1'b0; idle(3); Reset_n = 1'b1; idle(2);
    wlog.delete();
    send_byte(8'h55); send_byte(8'h66); idle(2);
    check("s5_write", wlog.size() == 1 ? wlog[0].addr * 65536 + wlog[0].data : -1, 32'h0_5566);

    // 6: low byte on the expiry cycle completes the pixel, no timeout
    wlog.delete(); n_to = 0;
    send_byte(8'h77); idle(99); send_byte(8'h88); idle(3);
    check("s6_write", wlog.size() == 1 ? wlog[0].addr * 65536 + wlog[0].data : -1, 32'h1_7788);
    check("s6_no_to", n_to, 0);
    // one edge later the high byte has already expired
    send_byte(8'h99); idle(100); send_byte(8'h98); idle(2);
    check("s6b_to", n_to, 1);

    // randomized traffic: short gaps, back-to-back bytes, timeout-boundary gaps, clr
    for (int i = 0; i < 500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 4) pulse_clr();
      else if (r < 8) begin
        clr = 1'b1; send_byte(8'($urandom)); clr = 1'b0;
      end else begin
        send_byte(8'($urandom));
        if (r < 14) idle(int'($urandom_range(97, 103)));
        else if (r < 60) idle(int'($urandom_range(0, 3)));
      end
    end
    idle(120);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
